// File: rtl/controlador_banco.sv
// Multicycle operand sequencer for the 8x16 register bank: accepts one instruction,
// reads its operands, computes a result and issues a single-cycle write-back.
module controlador_banco #(
    parameter int WIDTH = 16,
    parameter int ADDR  = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [2:0]       opcode,
    input  logic [ADDR-1:0]  rd,
    input  logic [ADDR-1:0]  rs,
    input  logic [ADDR-1:0]  rt,
    input  logic [WIDTH-1:0] imm,
    output logic [ADDR-1:0]  Read1,
    output logic [ADDR-1:0]  Read2,
    input  logic [WIDTH-1:0] Data1,
    input  logic [WIDTH-1:0] Data2,
    output logic [ADDR-1:0]  WriteReg,
    output logic [WIDTH-1:0] WriteData,
    output logic             RegWrite,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_READ  = 2'b01,
        ST_EXEC  = 2'b10,
        ST_WRITE = 2'b11
    } state_t;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_LDI = 3'b101;
    localparam logic [2:0] OP_MOV = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    state_t           r_state;
    state_t           w_next_state;
    logic [2:0]       r_opcode;
    logic [ADDR-1:0]  r_rd;
    logic [ADDR-1:0]  r_rs;
    logic [ADDR-1:0]  r_rt;
    logic [WIDTH-1:0] r_imm;
    logic [WIDTH-1:0] r_op_a;
    logic [WIDTH-1:0] r_op_b;
    logic [WIDTH-1:0] r_result;
    logic             r_ready;
    logic             r_regwrite;
    logic             r_done;
    logic [WIDTH-1:0] w_alu;
    logic             w_accept;

    assign w_accept = (r_state == ST_IDLE) && instr_valid;

    // Next-state decode
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (instr_valid) begin
                    if (opcode == OP_LDI) begin
                        w_next_state = ST_EXEC;
                    end else begin
                        w_next_state = ST_READ;
                    end
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_READ:  w_next_state = ST_EXEC;
            ST_EXEC:  w_next_state = ST_WRITE;
            ST_WRITE: w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    // Result datapath; arithmetic wraps modulo 2^WIDTH
    always_comb begin
        w_alu = {WIDTH{1'b0}};
        case (r_opcode)
            OP_ADD: w_alu = r_op_a + r_op_b;
            OP_SUB: w_alu = r_op_a - r_op_b;
            OP_AND: w_alu = r_op_a & r_op_b;
            OP_OR:  w_alu = r_op_a | r_op_b;
            OP_XOR: w_alu = r_op_a ^ r_op_b;
            OP_LDI: w_alu = r_imm;
            OP_MOV: w_alu = r_op_a;
            OP_SLT: begin
                if ($signed(r_op_a) < $signed(r_op_b)) begin
                    w_alu = {{(WIDTH-1){1'b0}}, 1'b1};
                end else begin
                    w_alu = {WIDTH{1'b0}};
                end
            end
            default: w_alu = {WIDTH{1'b0}};
        endcase
    end

    // State register and handshake/write-enable flags registered from the next state
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_ready    <= 1'b1;
            r_regwrite <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_ready    <= (w_next_state == ST_IDLE);
            r_regwrite <= (w_next_state == ST_WRITE);
            r_done     <= (w_next_state == ST_WRITE);
        end
    end

    // Instruction fields are sampled only at the accepting edge
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_opcode <= 3'b000;
            r_rd     <= {ADDR{1'b0}};
            r_rs     <= {ADDR{1'b0}};
            r_rt     <= {ADDR{1'b0}};
            r_imm    <= {WIDTH{1'b0}};
        end else if (w_accept) begin
            r_opcode <= opcode;
            r_rd     <= rd;
            r_rs     <= rs;
            r_rt     <= rt;
            r_imm    <= imm;
        end
    end

    // Operand capture at the end of READ, result capture at the end of EXEC
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_op_a   <= {WIDTH{1'b0}};
            r_op_b   <= {WIDTH{1'b0}};
            r_result <= {WIDTH{1'b0}};
        end else begin
            if (r_state == ST_READ) begin
                r_op_a <= Data1;
                r_op_b <= Data2;
            end
            if (r_state == ST_EXEC) begin
                r_result <= w_alu;
            end
        end
    end

    assign instr_ready = r_ready;
    assign Read1       = r_rs;
    assign Read2       = r_rt;
    assign WriteReg    = r_rd;
    assign WriteData   = r_result;
    assign RegWrite    = r_regwrite;
    assign done        = r_done;
    assign result      = r_result;

endmodule

// File: tb/tb_controlador_banco.sv
// Directed bench for controlador_banco with a behavioural 8x16 register bank attached.
module tb_controlador_banco;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_LDI = 3'b101;
    localparam logic [2:0] OP_MOV = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [2:0]  opcode = 3'b000;
    logic [2:0]  rd = 3'b000;
    logic [2:0]  rs = 3'b000;
    logic [2:0]  rt = 3'b000;
    logic [15:0] imm = 16'h0000;
    logic [2:0]  Read1;
    logic [2:0]  Read2;
    logic [15:0] Data1;
    logic [15:0] Data2;
    logic [2:0]  WriteReg;
    logic [15:0] WriteData;
    logic        RegWrite;
    logic        done;
    logic [15:0] result;

    logic [15:0] bank [8];
    logic        bank_clr = 1'b1;
    int          cyc = 0;
    int          pulse_cnt = 0;
    int          n_cmp = 0;
    int          n_err = 0;

    controlador_banco #(.WIDTH(16), .ADDR(3)) dut (
        .clock(clock), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .opcode(opcode), .rd(rd), .rs(rs), .rt(rt), .imm(imm),
        .Read1(Read1), .Read2(Read2), .Data1(Data1), .Data2(Data2),
        .WriteReg(WriteReg), .WriteData(WriteData), .RegWrite(RegWrite),
        .done(done), .result(result)
    );

    always #5 clock = ~clock;

    assign Data1 = bank[Read1];
    assign Data2 = bank[Read2];

    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (bank_clr) begin
            for (int i = 0; i < 8; i++) bank[i] <= 16'h0000;
        end else if (RegWrite) begin
            bank[WriteReg] <= WriteData;
        end
    end

    always @(negedge clock) begin
        if (RegWrite) pulse_cnt <= pulse_cnt + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_ready(input string nm);
        int n = 0;
        while (!instr_ready && n < 20) begin
            @(negedge clock);
            n++;
        end
        if (!instr_ready) begin
            n_cmp++; n_err++;
            $display("FAIL %s ready-timeout: instr_ready=%b required 1", nm, instr_ready);
        end
    endtask

    task automatic run_instr(input logic [2:0] op, input logic [2:0] d, input logic [2:0] s,
                             input logic [2:0] t, input logic [15:0] im,
                             input logic [15:0] exp, input string nm);
        int k;
        int exp_lat;
        exp_lat = (op == OP_LDI) ? 2 : 3;
        wait_ready(nm);
        opcode = op; rd = d; rs = s; rt = t; imm = im; instr_valid = 1'b1;
        @(posedge clock);
        @(negedge clock);
        instr_valid = 1'b0;
        opcode = 3'($urandom); rd = 3'($urandom); rs = 3'($urandom); rt = 3'($urandom);
        imm = 16'($urandom);
        if (op != OP_LDI) begin
            n_cmp++;
            if (Read1 !== s || Read2 !== t || instr_ready !== 1'b0) begin
                n_err++;
                $display("FAIL %s read-addr: Read1=%0d Read2=%0d ready=%b required %0d %0d 0",
                         nm, Read1, Read2, instr_ready, s, t);
            end
        end
        k = 1;
        while (!RegWrite && k < 8) begin
            @(negedge clock);
            k++;
        end
        n_cmp++;
        if (k != exp_lat) begin
            n_err++;
            $display("FAIL %s latency: RegWrite at cycle %0d required %0d", nm, k, exp_lat);
        end
        n_cmp++;
        if (RegWrite !== 1'b1 || done !== 1'b1 || WriteReg !== d || WriteData !== exp || result !== exp) begin
            n_err++;
            $display("FAIL %s writeback: RegWrite=%b done=%b WriteReg=%0d WriteData=%h result=%h required 1 1 %0d %h %h",
                     nm, RegWrite, done, WriteReg, WriteData, result, d, exp, exp);
        end
        @(negedge clock);
        n_cmp++;
        if (RegWrite !== 1'b0 || done !== 1'b0 || instr_ready !== 1'b1 || bank[d] !== exp) begin
            n_err++;
            $display("FAIL %s after-write: RegWrite=%b done=%b ready=%b bank=%h required 0 0 1 %h",
                     nm, RegWrite, done, instr_ready, bank[d], exp);
        end
    endtask

    task automatic test_reset();
        @(negedge clock);
        n_cmp++;
        if (instr_ready !== 1'b1 || RegWrite !== 1'b0 || done !== 1'b0 || Read1 !== 3'd0 ||
            Read2 !== 3'd0 || WriteReg !== 3'd0 || WriteData !== 16'h0000 || result !== 16'h0000) begin
            n_err++;
            $display("FAIL reset-initial: ready=%b RegWrite=%b done=%b R1=%0d R2=%0d WR=%0d WD=%h res=%h required 1 0 0 0 0 0 0 0",
                     instr_ready, RegWrite, done, Read1, Read2, WriteReg, WriteData, result);
        end
        reset = 1'b0;
        bank_clr = 1'b0;
        @(negedge clock);
        // abort an ADD in READ and check the asynchronous clear
        opcode = OP_ADD; rd = 3'd7; rs = 3'd5; rt = 3'd6; instr_valid = 1'b1;
        @(posedge clock);
        @(negedge clock);
        instr_valid = 1'b0;
        reset = 1'b1;
        #1;
        n_cmp++;
        if (instr_ready !== 1'b1 || RegWrite !== 1'b0 || done !== 1'b0 || Read1 !== 3'd0 ||
            Read2 !== 3'd0 || WriteReg !== 3'd0 || WriteData !== 16'h0000 || result !== 16'h0000) begin
            n_err++;
            $display("FAIL reset-midsim: ready=%b RegWrite=%b done=%b R1=%0d R2=%0d WR=%0d WD=%h required 1 0 0 0 0 0 0",
                     instr_ready, RegWrite, done, Read1, Read2, WriteReg, WriteData);
        end
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        n_cmp++;
        if (instr_ready !== 1'b1 || RegWrite !== 1'b0) begin
            n_err++;
            $display("FAIL reset-release: ready=%b RegWrite=%b required 1 0", instr_ready, RegWrite);
        end
    endtask

    task automatic test_add();
        run_instr(OP_LDI, 3'd1, 3'd0, 3'd0, 16'h1234, 16'h1234, "ldi_r1");
        run_instr(OP_LDI, 3'd2, 3'd0, 3'd0, 16'h00FF, 16'h00FF, "ldi_r2");
        run_instr(OP_ADD, 3'd3, 3'd1, 3'd2, 16'h0000, 16'h1333, "add_r3");
        run_instr(OP_MOV, 3'd6, 3'd3, 3'd0, 16'h0000, 16'h1333, "mov_r6_r3");
    endtask

    task automatic test_wrap_sign();
        run_instr(OP_LDI, 3'd0, 3'd0, 3'd0, 16'h0000, 16'h0000, "ldi_r0");
        run_instr(OP_LDI, 3'd4, 3'd0, 3'd0, 16'h0001, 16'h0001, "ldi_r4");
        run_instr(OP_SUB, 3'd5, 3'd0, 3'd4, 16'h0000, 16'hFFFF, "sub_wrap");
        run_instr(OP_LDI, 3'd6, 3'd0, 3'd0, 16'h8000, 16'h8000, "ldi_r6");
        run_instr(OP_SLT, 3'd7, 3'd6, 3'd4, 16'h0000, 16'h0001, "slt_neg_lt");
        run_instr(OP_SLT, 3'd7, 3'd4, 3'd6, 16'h0000, 16'h0000, "slt_pos_ge");
    endtask

    task automatic test_back_to_back();
        int acc [4];
        int n;
        int p0;
        wait_ready("b2b");
        p0 = pulse_cnt;
        opcode = OP_LDI; rd = 3'd1; rs = 3'd0; rt = 3'd0; imm = 16'h0005; instr_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n = 0;
            while (!instr_ready && n < 20) begin
                @(negedge clock);
                n++;
            end
            @(posedge clock);
            @(negedge clock);
            acc[i] = cyc;
            opcode = OP_ADD; rd = 3'd1; rs = 3'd1; rt = 3'd1;
        end
        instr_valid = 1'b0;
        repeat (6) @(negedge clock);
        n_cmp++;
        if (bank[1] !== 16'h0028) begin
            n_err++;
            $display("FAIL b2b-value: r1=%h required 0028", bank[1]);
        end
        n_cmp++;
        if (pulse_cnt - p0 != 4) begin
            n_err++;
            $display("FAIL b2b-pulses: RegWrite pulses=%0d required 4", pulse_cnt - p0);
        end
        n_cmp++;
        if (acc[1] - acc[0] != 3 || acc[2] - acc[1] != 4 || acc[3] - acc[2] != 4) begin
            n_err++;
            $display("FAIL b2b-spacing: accept gaps %0d %0d %0d required 3 4 4",
                     acc[1] - acc[0], acc[2] - acc[1], acc[3] - acc[2]);
        end
    endtask

    task automatic test_abort();
        int n = 0;
        wait_ready("abort");
        opcode = OP_XOR; rd = 3'd2; rs = 3'd1; rt = 3'd1; instr_valid = 1'b1;
        @(posedge clock);
        @(negedge clock);
        instr_valid = 1'b0;
        while (!RegWrite && n < 8) begin
            @(negedge clock);
            n++;
        end
        reset = 1'b1;
        #1;
        n_cmp++;
        if (RegWrite !== 1'b0 || done !== 1'b0 || instr_ready !== 1'b1 || n != 2) begin
            n_err++;
            $display("FAIL abort-reset: RegWrite=%b done=%b ready=%b wait=%0d required 0 0 1 2",
                     RegWrite, done, instr_ready, n);
        end
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        n_cmp++;
        if (bank[2] !== 16'h00FF || instr_ready !== 1'b1 || RegWrite !== 1'b0) begin
            n_err++;
            $display("FAIL abort-retain: r2=%h ready=%b RegWrite=%b required 00ff 1 0",
                     bank[2], instr_ready, RegWrite);
        end
    endtask

    task automatic test_idle_hold();
        logic [2:0]  r1_q;
        logic [2:0]  r2_q;
        logic [2:0]  wr_q;
        logic [15:0] wd_q;
        run_instr(OP_LDI, 3'd3, 3'd0, 3'd0, 16'hBEEF, 16'hBEEF, "idle_setup");
        r1_q = Read1; r2_q = Read2; wr_q = WriteReg; wd_q = WriteData;
        instr_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            opcode = 3'($urandom); rd = 3'($urandom); rs = 3'($urandom); rt = 3'($urandom);
            @(negedge clock);
            n_cmp++;
            if (RegWrite !== 1'b0 || done !== 1'b0 || Read1 !== r1_q || Read2 !== r2_q ||
                WriteReg !== wr_q || WriteData !== wd_q || instr_ready !== 1'b1) begin
                n_err++;
                $display("FAIL idle-hold[%0d]: RegWrite=%b done=%b R1=%0d R2=%0d WR=%0d WD=%h required 0 0 %0d %0d %0d %h",
                         i, RegWrite, done, Read1, Read2, WriteReg, WriteData, r1_q, r2_q, wr_q, wd_q);
            end
        end
        n_cmp++;
        if (wd_q !== 16'hBEEF || wr_q !== 3'd3) begin
            n_err++;
            $display("FAIL idle-held-values: WR=%0d WD=%h required 3 beef", wr_q, wd_q);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_wrap_sign();
        test_back_to_back();
        test_abort();
        test_idle_hold();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
